// File: rtl/dna_window_matcher.sv
// Sliding-window base matcher: compares every KEY_BASES window against a key and reports hits within threshold.
// Hit valid two edges after the completing base is accepted; a stalled hit freezes window, both stages and base_ready.
module dna_window_matcher #(
    parameter int KEY_BASES = 32,
    parameter int POS_WIDTH = 32,
    parameter int CNT_WIDTH = $clog2(KEY_BASES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   key_load,
    input  logic [2*KEY_BASES-1:0] key_in,
    input  logic [CNT_WIDTH-1:0]   threshold,
    input  logic                   start,
    input  logic                   base_valid,
    output logic                   base_ready,
    input  logic [1:0]             base_in,
    input  logic                   base_last,
    output logic                   hit_valid,
    input  logic                   hit_ready,
    output logic [POS_WIDTH-1:0]   hit_pos,
    output logic [CNT_WIDTH-1:0]   hit_mismatches,
    output logic                   hit_exact,
    output logic [POS_WIDTH-1:0]   hit_count,
    output logic                   busy,
    output logic                   done
);
    localparam int KW = 2 * KEY_BASES;

    typedef enum logic [1:0] {IDLE, FILL, SCAN, DRAIN} state_t;

    state_t               state;
    logic [KW-1:0]        key_q;
    logic [KW-1:0]        window;
    logic [KW-1:0]        window_nxt;
    logic [CNT_WIDTH-1:0] thr_q;
    logic [CNT_WIDTH-1:0] fill_cnt;
    logic [POS_WIDTH-1:0] pos_cnt;
    logic [KEY_BASES-1:0] mm_vec;
    logic [KEY_BASES-1:0] a_vec;
    logic [POS_WIDTH-1:0] a_pos;
    logic                 a_vld;
    logic [CNT_WIDTH-1:0] a_pop;
    logic                 stall;
    logic                 accept;
    logic                 complete;

    function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [KEY_BASES-1:0] v);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < KEY_BASES; i++) begin
            c = c + CNT_WIDTH'(v[i]);
        end
        return c;
    endfunction

    assign stall      = hit_valid && !hit_ready;
    assign base_ready = ((state == FILL) || (state == SCAN)) && !stall;
    assign accept     = base_valid && base_ready;
    assign busy       = (state != IDLE);
    // Newest base enters the least-significant slot, so the oldest sits where the key's first base does.
    assign window_nxt = {window[KW-3:0], base_in};
    assign complete   = accept && ((state == SCAN) ||
                        ((state == FILL) && (fill_cnt == CNT_WIDTH'(KEY_BASES - 1))));
    assign a_pop      = popcnt(a_vec);

    always_comb begin
        mm_vec = '0;
        for (int i = 0; i < KEY_BASES; i++) begin
            mm_vec[i] = (window_nxt[KW-1-2*i -: 2] != key_q[KW-1-2*i -: 2]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            key_q          <= '0;
            thr_q          <= '0;
            window         <= '0;
            fill_cnt       <= '0;
            pos_cnt        <= '0;
            a_vld          <= 1'b0;
            a_vec          <= '0;
            a_pos          <= '0;
            hit_valid      <= 1'b0;
            hit_pos        <= '0;
            hit_mismatches <= '0;
            hit_exact      <= 1'b0;
            hit_count      <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;

            if (hit_valid && hit_ready) begin
                hit_count <= hit_count + POS_WIDTH'(1);
            end

            if (accept) begin
                window  <= window_nxt;
                pos_cnt <= pos_cnt + POS_WIDTH'(1);
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + CNT_WIDTH'(1);
                end
            end

            if (!stall) begin
                a_vld <= complete;
                if (complete) begin
                    a_vec <= mm_vec;
                    a_pos <= pos_cnt + POS_WIDTH'(1) - POS_WIDTH'(KEY_BASES);
                end
                hit_valid <= a_vld && (a_pop <= thr_q);
                if (a_vld && (a_pop <= thr_q)) begin
                    hit_pos        <= a_pos;
                    hit_mismatches <= a_pop;
                    hit_exact      <= (a_pop == '0);
                end
            end

            case (state)
                IDLE: begin
                    if (key_load) begin
                        key_q <= key_in;
                    end
                    if (start) begin
                        thr_q     <= threshold;
                        window    <= '0;
                        fill_cnt  <= '0;
                        pos_cnt   <= '0;
                        hit_count <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (base_last) begin
                            state <= DRAIN;
                        end else if (fill_cnt == CNT_WIDTH'(KEY_BASES - 1)) begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (accept && base_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!a_vld && !hit_valid) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dna_window_matcher.sv
// Scoreboard bench for dna_window_matcher: a window-counting reference model queues expected hits, a monitor pops them.
module tb_dna_window_matcher;
    localparam int K  = 4;
    localparam int PW = 16;
    localparam int CW = $clog2(K + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          key_load = 1'b0;
    logic [2*K-1:0] key_in = '0;
    logic [CW-1:0] threshold = '0;
    logic          start = 1'b0;
    logic          base_valid = 1'b0;
    logic          base_ready;
    logic [1:0]    base_in = '0;
    logic          base_last = 1'b0;
    logic          hit_valid;
    logic          hit_ready = 1'b1;
    logic [PW-1:0] hit_pos;
    logic [CW-1:0] hit_mismatches;
    logic          hit_exact;
    logic [PW-1:0] hit_count;
    logic          busy;
    logic          done;

    dna_window_matcher #(.KEY_BASES(K), .POS_WIDTH(PW)) dut (
        .clock(clock), .reset_n(reset_n), .key_load(key_load), .key_in(key_in),
        .threshold(threshold), .start(start), .base_valid(base_valid),
        .base_ready(base_ready), .base_in(base_in), .base_last(base_last),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_pos(hit_pos),
        .hit_mismatches(hit_mismatches), .hit_exact(hit_exact),
        .hit_count(hit_count), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {int pos; int mm;} exp_t;

    int         checks = 0;
    int         errors = 0;
    int         ncyc = 0;
    int         rdy_mode = 0;
    int         hs_last_cyc = 0;
    int         hs_cyc[$];
    exp_t       exp_q[$];
    bit [1:0]   stream[$];

    always @(posedge clock) ncyc++;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // hit_ready policy: 0 = always ready, 1 = random, 2 = driven by a test directly
    initial forever begin
        @(posedge clock);
        #1;
        if (rdy_mode == 0) hit_ready = 1'b1;
        else if (rdy_mode == 1) hit_ready = ($urandom_range(0, 99) < 70);
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && hit_valid && hit_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hit: pos %0d mm %0d, no hit expected", hit_pos, hit_mismatches);
                end else begin
                    e = exp_q.pop_front();
                    if (hit_pos != PW'(e.pos) || hit_mismatches != CW'(e.mm) || hit_exact != (e.mm == 0)) begin
                        errors++;
                        $display("FAIL hit_record: got pos %0d mm %0d exact %0d, expected pos %0d mm %0d exact %0d",
                                 hit_pos, hit_mismatches, hit_exact, e.pos, e.mm, (e.mm == 0));
                    end
                end
            end
        end
    end

    task automatic set_str(input string s);
        stream.delete();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "A": stream.push_back(2'd0);
                "C": stream.push_back(2'd1);
                "G": stream.push_back(2'd2);
                default: stream.push_back(2'd3);
            endcase
        end
    endtask

    // Reference: count differing bases of every full window, keep those within threshold.
    task automatic model(input logic [2*K-1:0] key, input int thr, output int nexp);
        nexp = 0;
        for (int p = 0; p + K <= stream.size(); p++) begin
            int mm;
            mm = 0;
            for (int i = 0; i < K; i++) begin
                if (int'(stream[p+i]) != int'((key >> (2 * (K - 1 - i))) & 3)) mm++;
            end
            if (mm <= thr) begin
                exp_q.push_back('{pos: p, mm: mm});
                nexp++;
            end
        end
    endtask

    task automatic start_scan(input logic [2*K-1:0] key, input int thr, input bit load);
        @(posedge clock);
        #1;
        key_in = key; key_load = load; threshold = CW'(thr); start = 1'b1;
        @(posedge clock);
        #1;
        key_load = 1'b0; start = 1'b0;
    endtask

    task automatic drive(input int gap_max, input int kl_at);
        hs_cyc.delete();
        for (int i = 0; i < stream.size(); i++) begin
            int w;
            bit hs;
            base_valid = 1'b1;
            base_in    = stream[i];
            base_last  = (i == stream.size() - 1);
            if (i == kl_at) begin
                key_in = '1; key_load = 1'b1;
            end
            w = 0; hs = 1'b0;
            while (!hs && w < 300) begin
                @(negedge clock);
                hs = base_ready;
                if (hs) hs_cyc.push_back(ncyc);
                if (hs && base_last) hs_last_cyc = ncyc;
                @(posedge clock);
                #1;
                key_load = 1'b0;
                w++;
            end
            base_valid = 1'b0; base_last = 1'b0;
            if (!hs) begin
                check("base_accept_timeout", w, -1);
                return;
            end
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic wait_done(input string name, output int at_cyc);
        int w;
        bit got;
        w = 0; got = 1'b0; at_cyc = -1;
        while (!got && w < 400) begin
            @(negedge clock);
            if (done) begin got = 1'b1; at_cyc = ncyc; end
            w++;
        end
        check({name, "_done_seen"}, got, 1);
        @(negedge clock);
        check({name, "_done_one_pulse"}, done, 0);
        check({name, "_idle_after"}, busy, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic scan(input string name, input logic [2*K-1:0] key, input int thr, input bit load,
                        input int gap_max, input int kl_at, output int done_cyc);
        int nexp;
        model(key, thr, nexp);
        start_scan(key, thr, load);
        drive(gap_max, kl_at);
        wait_done(name, done_cyc);
        check({name, "_hit_count"}, hit_count, nexp);
        check({name, "_all_hits_seen"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int dc;
        int hv_cyc;
        int pulses;
        logic [2*K-1:0] rkey;

        repeat (3) @(posedge clock);
        #1;
        check("reset_hit_valid", hit_valid, 0);
        check("reset_base_ready", base_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hit_count", hit_count, 0);
        check("reset_hit_pos", hit_pos, 0);
        reset_n = 1'b1;

        set_str("ACGTACGT");
        scan("exact_two", 8'b00011011, 0, 1'b1, 0, -1, dc);

        set_str("ACTTGG");
        scan("approx_one", 8'b00011011, 1, 1'b1, 0, -1, dc);

        // Backpressure: hold the first hit for five cycles.
        set_str("ACGTACGT");
        rdy_mode = 2; hit_ready = 1'b0;
        begin
            int nexp;
            model(8'b00011011, 0, nexp);
            start_scan(8'b00011011, 0, 1'b1);
            fork
                drive(0, -1);
                begin
                    int w;
                    w = 0; hv_cyc = -1;
                    while (hv_cyc < 0 && w < 100) begin
                        @(negedge clock);
                        if (hit_valid) hv_cyc = ncyc;
                        w++;
                    end
                    check("bp_hit_seen", hv_cyc >= 0, 1);
                    check("hit_latency", hv_cyc - hs_cyc[3], 2);
                    repeat (5) begin
                        @(negedge clock);
                        check("bp_base_ready_low", base_ready, 0);
                        check("bp_hit_pos_held", hit_pos, 0);
                        check("bp_hit_valid_held", hit_valid, 1);
                    end
                    @(posedge clock);
                    #1;
                    hit_ready = 1'b1;
                end
            join
            wait_done("backpressure", dc);
            check("backpressure_hit_count", hit_count, nexp);
            check("backpressure_all_hits_seen", exp_q.size(), 0);
            exp_q.delete();
        end
        rdy_mode = 0;

        set_str("ACG");
        scan("short", 8'b00011011, 3, 1'b1, 0, -1, dc);
        check("short_done_latency", dc - hs_last_cyc, 2);

        set_str("ACGTACGT");
        scan("keyload_in_scan", 8'b00011011, 0, 1'b1, 0, 5, dc);
        set_str("TTTTTAT");
        scan("new_key", 8'b11111111, 0, 1'b1, 0, -1, dc);

        // Reset while a hit is stalled mid-scan.
        rdy_mode = 2; hit_ready = 1'b0;
        start_scan(8'b00011011, 0, 1'b1);
        set_str("ACGTAC");
        for (int i = 0; i < 6; i++) begin
            base_valid = 1'b1; base_in = stream[i];
            @(posedge clock);
            #1;
        end
        base_valid = 1'b0;
        @(negedge clock);
        check("pre_reset_hit_pending", hit_valid, 1);
        reset_n = 1'b0;
        #1;
        check("midreset_hit_valid", hit_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_base_ready", base_ready, 0);
        check("midreset_hit_pos", hit_pos, 0);
        check("midreset_hit_mm", hit_mismatches, 0);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_mode = 0;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("midreset_no_done", pulses, 0);
        set_str("ACGTACGT");
        scan("after_reset", 8'b00011011, 0, 1'b1, 0, -1, dc);

        rdy_mode = 1;
        for (int s = 0; s < 8; s++) begin
            int len;
            rkey = ($urandom & 8'hFF);
            len  = $urandom_range(1, 16);
            stream.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 1) stream.push_back(2'((rkey >> (2 * (K - 1 - (i % K)))) & 3));
                else stream.push_back(2'($urandom_range(0, 3)));
            end
            scan("random", rkey, $urandom_range(0, 4), 1'b1, 2, -1, dc);
        end
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end
endmodule
